// File: rtl/scope_grid_timing_gen.sv
// rtl/scope_grid_timing_gen.sv - raster timing and graticule pixel generator (optional dotted grid: SCOPE_GRID_DOTTED_EN)
module scope_grid_timing_gen #(
    parameter int H_ACTIVE    = 1920,
    parameter int H_FP        = 88,
    parameter int H_SYNC      = 44,
    parameter int H_BP        = 148,
    parameter int V_ACTIVE    = 1080,
    parameter int V_FP        = 4,
    parameter int V_SYNC      = 5,
    parameter int V_BP        = 36,
    parameter bit SYNC_POL    = 1'b1,
    parameter int PX0         = 442,
    parameter int PX1         = 1522,
    parameter int PY0         = 9,
    parameter int PY1         = 1075,
    parameter int GRID_X_STEP = 108,
    parameter int GRID_Y_STEP = 96
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic [23:0] bg_color,
    input  logic [23:0] grid_color,
    input  logic [23:0] border_color,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [23:0] o_data,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [11:0] X0       = 12'(PX0);
    localparam logic [11:0] X1       = 12'(PX1);
    localparam logic [11:0] Y0       = 12'(PY0);
    localparam logic [11:0] Y1       = 12'(PY1);
    localparam logic [11:0] GX_LAST  = 12'(GRID_X_STEP - 1);
    localparam logic [11:0] GY_LAST  = 12'(GRID_Y_STEP - 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [11:0] gx_reg;
    logic [11:0] gy_reg;
    logic [11:0] gx_cur;
    logic [11:0] gy_cur;
    logic [23:0] bg_sh;
    logic [23:0] grid_sh;
    logic [23:0] border_sh;
    logic        line_end;
    logic        frame_end;
    logic        de_raw;
    logic        hs_raw;
    logic        vs_raw;
    logic        in_win;
    logic        on_border;
    logic        vgrid;
    logic        hgrid;
    logic [23:0] pix;

    assign line_end  = (state == ST_RUN) && (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);

    // Run/hold state register
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Enable is only honoured at frame end, so a frame is never cut short
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (frame_end && !i_en) state_nxt = ST_HOLD;
            ST_HOLD: if (i_en) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    // Raster counters; parked at the origin while holding
    always_ff @(posedge pclk) begin
        if (!rst_n || state == ST_HOLD) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (line_end) begin
            h_cnt <= 12'd0;
            v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    // Grid phase restarts on the plot edge so no modulo divider is needed
    always_comb begin
        gx_cur = (h_cnt == X0) ? 12'd0 : gx_reg;
        gy_cur = (v_cnt == Y0) ? 12'd0 : gy_reg;
    end

    // Grid phase counters: gx per pixel, gy per line
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            gx_reg <= 12'd0;
            gy_reg <= 12'd0;
        end else if (state == ST_RUN) begin
            gx_reg <= (gx_cur == GX_LAST) ? 12'd0 : gx_cur + 12'd1;
            if (line_end) begin
                gy_reg <= (gy_cur == GY_LAST) ? 12'd0 : gy_cur + 12'd1;
            end
        end
    end

    // Colour shadows: frame-end only, so a frame is always drawn in one palette;
    // also loaded during reset so the first frame has a defined palette
    always_ff @(posedge pclk) begin
        if (!rst_n || frame_end) begin
            bg_sh     <= bg_color;
            grid_sh   <= grid_color;
            border_sh <= border_color;
        end
    end

    // Timing decode for the current counter state
    always_comb begin
        de_raw    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_raw    = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        vs_raw    = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
        in_win    = (h_cnt >= X0) && (h_cnt <= X1) && (v_cnt >= Y0) && (v_cnt <= Y1);
        on_border = (h_cnt == X0) || (h_cnt == X1) || (v_cnt == Y0) || (v_cnt == Y1);
    end

    // Grid line hit test; dotted build blanks alternate 4-pixel runs
    always_comb begin
`ifdef SCOPE_GRID_DOTTED_EN
        vgrid = (gx_cur == 12'd0) && (((v_cnt - Y0) & 12'd4) == 12'd0);
        hgrid = (gy_cur == 12'd0) && (((h_cnt - X0) & 12'd4) == 12'd0);
`else
        vgrid = (gx_cur == 12'd0);
        hgrid = (gy_cur == 12'd0);
`endif
    end

    // Pixel colour in priority order: blank, outside window, border, grid, background
    always_comb begin
        pix = 24'd0;
        if (de_raw && in_win) begin
            if (on_border) begin
                pix = border_sh;
            end else if (vgrid || hgrid) begin
                pix = grid_sh;
            end else begin
                pix = bg_sh;
            end
        end
    end

    // Output register stage: every output lags the counters by one pclk
    always_ff @(posedge pclk) begin
        if (!rst_n || state == ST_HOLD) begin
            o_hs          <= ~SYNC_POL;
            o_vs          <= ~SYNC_POL;
            o_de          <= 1'b0;
            o_data        <= 24'd0;
            o_x           <= 12'd0;
            o_y           <= 12'd0;
            o_frame_start <= 1'b0;
        end else begin
            o_hs          <= hs_raw ? SYNC_POL : ~SYNC_POL;
            o_vs          <= vs_raw ? SYNC_POL : ~SYNC_POL;
            o_de          <= de_raw;
            o_data        <= pix;
            o_x           <= h_cnt;
            o_y           <= v_cnt;
            o_frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
        end
    end

endmodule

// File: tb/tb_scope_grid_timing_gen.sv
// tb/tb_scope_grid_timing_gen.sv - self-checking bench for scope_grid_timing_gen
module tb_scope_grid_timing_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int PX0 = 2, PX1 = 13, PY0 = 1, PY1 = 6, GXS = 4, GYS = 3;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_en = 1'b1;
    logic [23:0] bg_color = 24'h000010;
    logic [23:0] grid_color = 24'h00FF00;
    logic [23:0] border_color = 24'hFFFFFF;
    logic        o_hs, o_vs, o_de, o_frame_start;
    logic [23:0] o_data;
    logic [11:0] o_x, o_y;

    always #5 pclk = ~pclk;

    scope_grid_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1),
        .PX0(PX0), .PX1(PX1), .PY0(PY0), .PY1(PY1),
        .GRID_X_STEP(GXS), .GRID_Y_STEP(GYS)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .i_en(i_en),
        .bg_color(bg_color), .grid_color(grid_color), .border_color(border_color),
        .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_data(o_data),
        .o_x(o_x), .o_y(o_y), .o_frame_start(o_frame_start)
    );

    typedef struct {
        logic [3:0]  ctl;
        logic [23:0] data;
        logic [11:0] x;
        logic [11:0] y;
        bit          chk_data;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          running = 1'b1;
    int          pos = 0;
    bit          sh_valid = 1'b0;
    logic [23:0] sh_bg, sh_grid, sh_border;
    int          de_cnt = 0, fs_cnt = 0, hs_cnt = 0;

    function automatic logic [23:0] px(input int x, input int y);
        bit vg, hg;
        if (!(x < HA && y < VA)) return 24'd0;
        if (x < PX0 || x > PX1 || y < PY0 || y > PY1) return 24'd0;
        if (x == PX0 || x == PX1 || y == PY0 || y == PY1) return sh_border;
        vg = ((x - PX0) % GXS) == 0;
        hg = ((y - PY0) % GYS) == 0;
`ifdef SCOPE_GRID_DOTTED_EN
        vg = vg && (((y - PY0) / 4) % 2 == 0);
        hg = hg && (((x - PX0) / 4) % 2 == 0);
`endif
        if (vg || hg) return sh_grid;
        return sh_bg;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int h, v;
        e.ctl = 4'b0000; e.data = 24'd0; e.x = 12'd0; e.y = 12'd0; e.chk_data = 1'b1;
        if (!rst_n || !running) return e;
        h = pos % HT;
        v = pos / HT;
        e.ctl = {(h >= HA + HF) && (h <= HA + HF + HS - 1),
                 (v >= VA + VF) && (v <= VA + VF + VS - 1),
                 (h < HA) && (v < VA),
                 pos == 0};
        e.x = 12'(h);
        e.y = 12'(v);
        e.data = px(h, v);
        e.chk_data = sh_valid;
        return e;
    endfunction

    // one pclk: predict, advance model, clock, compare
    task automatic step();
        exp_t e, g;
        e = model_out();
        sb.push_back(e);
        if (!rst_n) begin
            running = 1'b1; pos = 0; sh_valid = 1'b0;
        end else if (!running) begin
            if (i_en) begin running = 1'b1; pos = 0; end
        end else if (pos == FT - 1) begin
            sh_bg = bg_color; sh_grid = grid_color; sh_border = border_color;
            sh_valid = 1'b1;
            pos = 0;
            if (!i_en) running = 1'b0;
        end else begin
            pos++;
        end
        @(posedge pclk);
        #1;
        cyc++;
        g = sb.pop_front();
        tests++;
        assert ({o_hs, o_vs, o_de, o_frame_start} === g.ctl) else begin
            fails++;
            $error("FAIL ctl cyc=%0d got hs/vs/de/fs=%b exp %b", cyc, {o_hs, o_vs, o_de, o_frame_start}, g.ctl);
        end
        if (g.ctl[1]) begin
            tests++;
            assert ({o_x, o_y} === {g.x, g.y}) else begin
                fails++;
                $error("FAIL xy cyc=%0d got (%0d,%0d) exp (%0d,%0d)", cyc, o_x, o_y, g.x, g.y);
            end
        end
        if (g.chk_data) begin
            tests++;
            assert (o_data === g.data) else begin
                fails++;
                $error("FAIL data cyc=%0d at (%0d,%0d) got %h exp %h", cyc, o_x, o_y, o_data, g.data);
            end
        end
        if (o_de === 1'b1) de_cnt++;
        if (o_frame_start === 1'b1) fs_cnt++;
        if (o_hs === 1'b1) hs_cnt++;
    endtask

    task automatic run_to(input int p);
        int n;
        n = 0;
        while (pos != p && n < FT + 4) begin
            step();
            n++;
        end
        if (pos != p) begin
            fails++;
            $error("FAIL run_to timeout pos=%0d want %0d", pos, p);
        end
    endtask

    task automatic spot(input int x, input int y, input logic [23:0] exp_d, input string tag);
        run_to(y * HT + x);
        step();
        tests++;
        assert (o_de === 1'b1 && o_x === 12'(x) && o_y === 12'(y) && o_data === exp_d) else begin
            fails++;
            $error("FAIL %s got de=%b (%0d,%0d) data=%h exp (%0d,%0d) data=%h", tag, o_de, o_x, o_y, o_data, x, y, exp_d);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_en = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (FT) step();

        de_cnt = 0; fs_cnt = 0; hs_cnt = 0;
        spot(0, 0, 24'h000000, "px_origin");
        spot(2, 3, 24'hFFFFFF, "px_border");
        spot(6, 3, 24'h00FF00, "px_grid");
        spot(7, 3, 24'h000010, "px_bg");
`ifdef SCOPE_GRID_DOTTED_EN
        spot(6, 5, 24'h000010, "px_dot_gap");
`else
        spot(6, 5, 24'h00FF00, "px_grid_solid");
`endif
        run_to(0);
        tests++;
        assert (de_cnt == HA * VA) else begin fails++; $error("FAIL de_per_frame got %0d exp %0d", de_cnt, HA * VA); end
        tests++;
        assert (fs_cnt == 1) else begin fails++; $error("FAIL fs_per_frame got %0d exp 1", fs_cnt); end
        tests++;
        assert (hs_cnt == HS * VT) else begin fails++; $error("FAIL hs_per_frame got %0d exp %0d", hs_cnt, HS * VT); end

        run_to(30);
        grid_color = 24'hFF0000;
        spot(6, 3, 24'h00FF00, "grid_shadow_old");
        run_to(0);
        spot(6, 3, 24'hFF0000, "grid_shadow_new");
        run_to(0);

        run_to(50);
        i_en = 1'b0;
        run_to(0);
        de_cnt = 0; hs_cnt = 0;
        repeat (100) step();
        tests++;
        assert (de_cnt == 0 && hs_cnt == 0 && o_vs === 1'b0) else begin
            fails++;
            $error("FAIL hold_idle got de_cnt=%0d hs_cnt=%0d vs=%b exp 0 0 0", de_cnt, hs_cnt, o_vs);
        end
        i_en = 1'b1;
        step();
        tests++;
        assert (o_frame_start === 1'b0) else begin fails++; $error("FAIL resume_early got fs=%b exp 0", o_frame_start); end
        step();
        tests++;
        assert (o_frame_start === 1'b1 && o_de === 1'b1 && o_x === 12'd0 && o_y === 12'd0) else begin
            fails++;
            $error("FAIL resume_origin got fs=%b de=%b (%0d,%0d) exp 1 1 (0,0)", o_frame_start, o_de, o_x, o_y);
        end

        run_to(4 * HT + 10);
        rst_n = 1'b0;
        step();
        tests++;
        assert (o_de === 1'b0 && o_x === 12'd0 && o_y === 12'd0 && o_data === 24'd0) else begin
            fails++;
            $error("FAIL reset_mid got de=%b (%0d,%0d) data=%h exp 0 (0,0) 0", o_de, o_x, o_y, o_data);
        end
        repeat (2) step();
        rst_n = 1'b1;
        step();
        tests++;
        assert (o_frame_start === 1'b1 && o_de === 1'b1 && o_x === 12'd0 && o_y === 12'd0) else begin
            fails++;
            $error("FAIL reset_release got fs=%b de=%b (%0d,%0d) exp 1 1 (0,0)", o_frame_start, o_de, o_x, o_y);
        end
        repeat (FT) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
